// File: rtl/sap_ram_loader.sv
// SAP-1 program loader: takes bytes from a valid/ready stream and writes them into the
// 16x8 RAM over the shared bus, optionally reading each one back, while the CPU is halted.
module sap_ram_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [7:0]        bus_in,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              ram_address_enable,
    output logic              ram_write_enable,
    output logic              ram_output_enable,
    output logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] load_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_WR,
        S_RD,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_data;
    logic [ADDR_W-1:0] r_addr;
    logic              w_last;
    logic              w_rd_ok;
    logic              w_restart;
    logic              w_advance;

    assign w_last    = (r_addr == ADDR_W'(DEPTH - 1));
    assign w_rd_ok   = (bus_in == r_data);
    assign w_restart = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    // The address step is folded into the WR/RD exit, so a byte costs WAIT+ADDR+WR(+RD)
    assign w_advance = (r_state == S_WR || r_state == S_RD) && (w_next == S_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (start) w_next = S_WAIT;
                S_WAIT:                if (in_valid) w_next = S_ADDR;
                S_ADDR:                w_next = S_WR;
                S_WR: begin
                    if (VERIFY != 0) w_next = S_RD;
                    else             w_next = w_last ? S_DONE : S_WAIT;
                end
                S_RD: begin
                    if (!w_rd_ok) w_next = S_ERR;
                    else          w_next = w_last ? S_DONE : S_WAIT;
                end
                default:               w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
            r_data <= '0;
        end else begin
            if (abort || w_restart) begin
                r_addr <= '0;
            end else if (w_advance) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (r_state == S_WAIT && in_valid && !abort) begin
                r_data <= in_data;
            end
        end
    end

    always_comb begin
        in_ready           = 1'b0;
        bus_out            = '0;
        bus_oe             = 1'b0;
        ram_address_enable = 1'b0;
        ram_write_enable   = 1'b0;
        ram_output_enable  = 1'b0;
        cpu_halt           = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        error              = 1'b0;
        load_addr          = r_addr;
        case (r_state)
            S_WAIT: begin
                in_ready = !abort;
                cpu_halt = 1'b1;
                busy     = 1'b1;
            end
            S_ADDR: begin
                bus_oe             = 1'b1;
                bus_out            = 8'(r_addr);
                ram_address_enable = 1'b1;
                cpu_halt           = 1'b1;
                busy               = 1'b1;
            end
            S_WR: begin
                bus_oe           = 1'b1;
                bus_out          = r_data;
                ram_write_enable = 1'b1;
                cpu_halt         = 1'b1;
                busy             = 1'b1;
            end
            S_RD: begin
                ram_output_enable = 1'b1;
                cpu_halt          = 1'b1;
                busy              = 1'b1;
            end
            S_DONE: done = 1'b1;
            S_ERR: begin
                error    = 1'b1;
                cpu_halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sap_ram_loader.sv
// Bench for sap_ram_loader: models the SAP-1 RAM on the bus and checks every cycle against
// a schedule-based reference of the load protocol; a second instance covers VERIFY=0.
module tb_sap_ram_loader;

    localparam int DEPTH   = 16;
    localparam int VERIFY1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, bus_oe, ram_address_enable, ram_write_enable, ram_output_enable;
    logic       cpu_halt, busy, done, error;
    logic [7:0] bus_out;
    logic [3:0] load_addr;

    logic       start2, abort2, in_valid2;
    logic [7:0] in_data2;
    logic       in_ready2, bus_oe2, ram_address_enable2, ram_write_enable2, ram_output_enable2;
    logic       cpu_halt2, busy2, done2, error2;
    logic [7:0] bus_out2;
    logic [3:0] load_addr2;

    int nchk = 0;
    int npass = 0;

    logic [7:0] img     [DEPTH];
    logic [7:0] ram1    [DEPTH] = '{default: 8'hEE};
    logic [7:0] exp_ram [DEPTH] = '{default: 8'hEE};
    logic [7:0] ram2    [DEPTH] = '{default: 8'hEE};
    logic [3:0] a1 = '0;
    logic [3:0] a2 = '0;
    logic [7:0] bus1, bus_in1, bus2;
    logic       inj_en = 1'b0;
    logic [3:0] inj_addr = '0;

    // RAM side of the shared bus; an undriven bus reads as 0
    assign bus1    = bus_oe ? bus_out : (ram_output_enable ? ram1[a1] : 8'h00);
    assign bus_in1 = (inj_en && ram_output_enable && load_addr == inj_addr) ? 8'hFF : bus1;
    assign bus2    = bus_oe2 ? bus_out2 : (ram_output_enable2 ? ram2[a2] : 8'h00);

    always @(posedge clk) begin
        if (ram_address_enable) a1 <= bus1[3:0];
        if (ram_write_enable) ram1[a1] <= bus1;
        if (ram_address_enable2) a2 <= bus2[3:0];
        if (ram_write_enable2) ram2[a2] <= bus2;
    end

    sap_ram_loader #(.DEPTH(DEPTH), .ADDR_W(4), .VERIFY(VERIFY1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .bus_in(bus_in1), .bus_out(bus_out), .bus_oe(bus_oe),
        .ram_address_enable(ram_address_enable), .ram_write_enable(ram_write_enable),
        .ram_output_enable(ram_output_enable), .cpu_halt(cpu_halt), .busy(busy),
        .done(done), .error(error), .load_addr(load_addr)
    );

    sap_ram_loader #(.DEPTH(DEPTH), .ADDR_W(4), .VERIFY(0)) dut_nv (
        .clk(clk), .reset_n(reset_n), .start(start2), .abort(abort2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .bus_in(bus2), .bus_out(bus_out2), .bus_oe(bus_oe2),
        .ram_address_enable(ram_address_enable2), .ram_write_enable(ram_write_enable2),
        .ram_output_enable(ram_output_enable2), .cpu_halt(cpu_halt2), .busy(busy2),
        .done(done2), .error(error2), .load_addr(load_addr2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct packed {
        logic       rdy, oe;
        logic [7:0] bo;
        logic       ae, we, re, halt, busy, dn, er;
        logic [3:0] la;
    } outv_t;

    // Reference: a load is a queue of bus steps (1=address, 2=write, 3=read-back) per byte
    typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mmode_t;
    mmode_t     m_mode = M_IDLE;
    int         m_addr = 0;
    logic [7:0] m_data = '0;
    int         sq[$];

    function automatic outv_t expected();
        outv_t e;
        e = '0;
        e.la = 4'(m_addr);
        case (m_mode)
            M_LOAD: begin
                e.halt = 1'b1;
                e.busy = 1'b1;
                if (sq.size() == 0) e.rdy = !abort;
                else if (sq[0] == 1) begin e.oe = 1'b1; e.bo = 8'(m_addr); e.ae = 1'b1; end
                else if (sq[0] == 2) begin e.oe = 1'b1; e.bo = m_data; e.we = 1'b1; end
                else e.re = 1'b1;
            end
            M_DONE: e.dn = 1'b1;
            M_ERR:  begin e.er = 1'b1; e.halt = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_advance();
        int s;
        if (!reset_n) begin
            m_mode = M_IDLE;
            m_addr = 0;
            sq.delete();
            return;
        end
        if (m_mode == M_LOAD && sq.size() > 0 && sq[0] == 2) exp_ram[m_addr] = m_data;
        if (abort) begin
            m_mode = M_IDLE;
            m_addr = 0;
            sq.delete();
        end else if (m_mode == M_LOAD) begin
            if (sq.size() == 0) begin
                if (in_valid) begin
                    m_data = in_data;
                    sq.push_back(1);
                    sq.push_back(2);
                    if (VERIFY1 != 0) sq.push_back(3);
                end
            end else begin
                s = sq.pop_front();
                if (s == 3 && bus_in1 != m_data) begin
                    m_mode = M_ERR;
                    sq.delete();
                end else if (sq.size() == 0) begin
                    if (m_addr == DEPTH - 1) m_mode = M_DONE;
                    else m_addr++;
                end
            end
        end else if (start) begin
            m_mode = M_LOAD;
            m_addr = 0;
        end
    endtask

    always @(negedge clk) begin : cmp
        outv_t act;
        act = {in_ready, bus_oe, bus_out, ram_address_enable, ram_write_enable,
               ram_output_enable, cpu_halt, busy, done, error, load_addr};
        chk("cycle_outputs", act, expected());
        chk("no_contention", {bus_oe & ram_output_enable, ram_address_enable & ram_write_enable}, 0);
        chk("nv_strobes", {bus_oe2 & ram_output_enable2, ram_address_enable2 & ram_write_enable2,
                           ram_output_enable2}, 0);
        model_advance();
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_load();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic ram_cmp(input string nm);
        for (int i = 0; i < DEPTH; i++) chk(nm, ram1[i], exp_ram[i]);
    endtask

    task automatic randomize_img();
        for (int i = 0; i < DEPTH; i++) img[i] = 8'($urandom);
    endtask

    // Streams img; stall_len counts only cycles in which the loader is waiting for byte stall_idx
    task automatic stream(input int stall_idx, input int stall_len, input int gap,
                          input int abort_at, input int start_at, output int n);
        int i = 0;
        int g = 0;
        int st = stall_len;
        logic hs;
        n = 0;
        while (i < DEPTH && g < 1000 && !error) begin
            in_data = img[i];
            if (i == stall_idx && st > 0) begin
                in_valid = 1'b0;
                if (in_ready) st--;
            end else begin
                in_valid = ($urandom_range(0, 99) >= gap);
            end
            start = (i == start_at);
            abort = (abort_at >= 0 && ram_write_enable && load_addr == 4'(abort_at));
            hs = in_valid && in_ready;
            step();
            n++;
            g++;
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                in_valid = 1'b0;
                return;
            end
            if (hs) i++;
        end
        in_valid = 1'b0;
        while (busy && g < 1000) begin
            step();
            n++;
            g++;
        end
        chk("load_settled", busy, 0);
    endtask

    initial begin
        int n;
        start = 0; abort = 0; in_valid = 0; in_data = 0;
        start2 = 0; abort2 = 0; in_valid2 = 0; in_data2 = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_load_addr", load_addr, 0);
        chk("rst_halt", cpu_halt, 0);
        reset_n = 1'b1;
        step();

        // back-to-back image 0x00..0x0F
        for (int i = 0; i < DEPTH; i++) img[i] = 8'(i);
        begin_load();
        stream(-1, 0, 0, -1, -1, n);
        chk("t1_latency", n, 64);
        chk("t1_done", done, 1);
        chk("t1_error", error, 0);
        chk("t1_halt", cpu_halt, 0);
        for (int i = 0; i < DEPTH; i++) chk("t1_ram", ram1[i], i);

        // source stalls 5 waiting cycles before byte 3
        randomize_img();
        img[3] = 8'hA5;
        begin_load();
        stream(3, 5, 0, -1, -1, n);
        chk("t2_latency", n, 69);
        chk("t2_ram3", ram1[3], 8'hA5);
        chk("t2_done", done, 1);
        ram_cmp("t2_ram");

        // read-back of address 7 corrupted
        randomize_img();
        img[7] = 8'h3C;
        inj_addr = 4'd7;
        inj_en = 1'b1;
        begin_load();
        stream(-1, 0, 0, -1, -1, n);
        inj_en = 1'b0;
        chk("t3_error", error, 1);
        chk("t3_load_addr", load_addr, 7);
        chk("t3_halt", cpu_halt, 1);
        chk("t3_done", done, 0);
        chk("t3_ram7", ram1[7], 8'h3C);

        // abort during the write of address 9 (restart from ERR)
        randomize_img();
        begin_load();
        stream(-1, 0, 0, 9, -1, n);
        chk("t4_idle", {in_ready, bus_oe, bus_out, ram_address_enable, ram_write_enable,
                        ram_output_enable, cpu_halt, busy, done, error, load_addr}, 0);
        chk("t4_ram8", ram1[8], img[8]);
        ram_cmp("t4_ram");

        // start while busy is ignored; start from DONE reloads
        randomize_img();
        begin_load();
        stream(-1, 0, 0, -1, 5, n);
        chk("t5_latency", n, 64);
        chk("t5_done", done, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_restart_done", done, 0);
        chk("t5_restart_busy", busy, 1);
        chk("t5_restart_addr", load_addr, 0);
        randomize_img();
        stream(-1, 0, 0, -1, -1, n);
        chk("t5_done2", done, 1);
        ram_cmp("t5_ram");

        // random source gaps
        for (int r = 0; r < 3; r++) begin
            randomize_img();
            begin_load();
            stream(-1, 0, 30, -1, -1, n);
            chk("rnd_done", done, 1);
            ram_cmp("rnd_ram");
        end

        // VERIFY=0 instance: WAIT+ADDR+WR per byte
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        in_valid2 = 1'b1;
        in_data2 = 8'h00;
        n = 0;
        while (cpu_halt2 && n < 300) begin
            logic hs2;
            hs2 = in_ready2;
            step();
            n++;
            if (hs2) in_data2 = in_data2 + 8'd1;
        end
        in_valid2 = 1'b0;
        chk("nv_latency", n, 48);
        chk("nv_done", done2, 1);
        chk("nv_error", error2, 0);
        chk("nv_busy", busy2, 0);
        chk("nv_load_addr", load_addr2, 15);
        for (int i = 0; i < DEPTH; i++) chk("nv_ram", ram2[i], i);

        step();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
